on_off_scheduler: RTL and testbench
===================================

Name: on_off_scheduler

Overview:
Sequences the channel mute control (mode: 1 = data_out forced to 0, 0 = data passes) for a transmit channel. Generates a programmable burst pattern of ON periods (data passes) and OFF periods (muted), counted in symbol strobes. Supports a fixed burst count or continuous operation, with graceful start/stop. Sits between the modem control registers and the channel on/off gate.

Parameters:
CNT_W, 16, width of the ON/OFF period length counters (in symbol strobes)
BURST_W, 8, width of the burst-count configuration and counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
sym_en  input  1  symbol strobe; counters advance only on cycles with sym_en=1
start  input  1  request to begin a burst sequence; single-cycle pulse or level, sampled in IDLE only
stop  input  1  request to end the sequence gracefully; sampled every cycle
cfg_on_len  input  CNT_W  ON period length in strobes; 0 treated as 1
cfg_off_len  input  CNT_W  OFF period length in strobes; 0 = no gap between bursts
cfg_bursts  input  BURST_W  number of bursts; 0 = continuous until stop
mode  output  1  mute control to channel gate; 1 = muted
busy  output  1  high while not IDLE
burst_start  output  1  one-cycle pulse in the first cycle of each ON period
done  output  1  one-cycle pulse in the first cycle back in IDLE

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low. During and after reset: state IDLE, mode=1, busy=0, burst_start=0, done=0, all counters 0, stop_pending=0.
- All outputs are registered. States: IDLE, ON, OFF.
- IDLE: mode=1. On start=1 and stop=0, latch cfg_on_len, cfg_off_len and cfg_bursts into shadow registers. Next cycle: ON, mode=0, burst_start=1, busy=1. When start=1 and stop=1 together, stop wins and the state stays IDLE. cfg_* changes while busy have no effect until the next start.
- ON: mode=0. The period counter is cleared on entry. On each sym_en, if cnt == on_len-1 (on_len=0 treated as 1), the period ends; otherwise cnt increments. ON therefore lasts exactly on_len strobes.
- End of ON, in priority order:
  - stop_pending, or the last burst (burst_cnt+1 == cfg_bursts, with cfg_bursts != 0): go to IDLE; done=1 and mode=1 on the next cycle.
  - off_len == 0: re-enter ON directly; mode stays 0 and burst_start pulses again.
  - Otherwise: go to OFF; mode=1 on the next cycle.
- OFF: mode=1. Counts off_len strobes the same way as ON. At the end of the period, go to ON with burst_start=1.
- Stop in OFF: go to IDLE on the next cycle, with done=1 and no further burst.
- Stop in ON: set stop_pending. The current ON period always completes; an ON period is never truncated.
- burst_cnt increments at each end of ON. In continuous mode (cfg_bursts=0) it saturates at all-ones.
- The mode transition is registered: mode changes in the cycle after the strobe that ends a period.
- sym_en=0 freezes the counters; the state holds.
- Reset asserted mid-sequence: immediate return to IDLE with mode=1, no done pulse.
- start while busy: ignored.
- stop in IDLE: ignored; stop_pending stays 0.
- done and burst_start are never asserted in the same cycle.

Test Plan:
1. Fixed bursts. sym_en=1 constantly; on_len=3, off_len=2, bursts=2; start pulse in cycle 0.
   Required: mode=0 in cycles 1-3, 1 in 4-5, 0 in 6-8, 1 from cycle 9. burst_start in cycles 1 and 6. done in cycle 9. busy high in cycles 1-8.
2. Continuous with stop in ON. bursts=0, on_len=4, off_len=1; stop pulse in cycle 2, which is inside ON.
   Required: mode stays 0 through cycle 4, IDLE in cycle 5 with done=1, no further burst_start.
3. Stop in OFF and zero-length periods.
   - on_len=2, off_len=3, bursts=0; stop in cycle 4, which is in OFF. Required: IDLE and done in cycle 5; mode held 1 throughout.
   - on_len=0, off_len=0, bursts=3. Required: mode=0 for 3 consecutive cycles, burst_start in each, then done.
4. Strobe gating. sym_en=1 every 4th cycle; on_len=2, off_len=1, bursts=1.
   Required: mode=0 from start+1 until the cycle after the 2nd strobe; done in that same cycle; counter frozen between strobes.
5. Reset and request collisions.
   - rst_n asserted mid-ON. Required: mode=1, busy=0 asynchronously; no done pulse after release.
   - start+stop together in IDLE. Required: no transition.
   - start while busy. Required: no restart.
   - cfg_on_len changed while busy. Required: no effect on the current sequence.

Source files
------------

// File: rtl/on_off_scheduler.sv
// Burst ON/OFF mute sequencer: drives the channel gate with programmable ON/OFF periods counted in symbol strobes.
// All outputs registered; mode changes one cycle after the strobe that ends a period.

module on_off_scheduler #(
   parameter int CNT_W   = 16,
   parameter int BURST_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sym_en,
   input  logic               start,
   input  logic               stop,
   input  logic [CNT_W-1:0]   cfg_on_len,
   input  logic [CNT_W-1:0]   cfg_off_len,
   input  logic [BURST_W-1:0] cfg_bursts,
   output logic               mode,
   output logic               busy,
   output logic               burst_start,
   output logic               done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   on_len_q, on_len_d;
   logic [CNT_W-1:0]   off_len_q, off_len_d;
   logic [BURST_W-1:0] bursts_q, bursts_d;
   logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
   logic               stop_pend_q, stop_pend_d;
   logic               mode_q, mode_d;
   logic               busy_q, busy_d;
   logic               bs_q, bs_d;
   logic               done_q, done_d;

   logic [CNT_W-1:0]   on_last;
   logic [CNT_W-1:0]   off_last;
   logic [BURST_W-1:0] burst_cnt_inc;
   logic               last_burst;
   logic               on_end;
   logic               off_end;

   // An ON length of zero behaves as a single strobe.
   assign on_last       = (on_len_q == '0) ? '0 : on_len_q - CNT_W'(1);
   assign off_last      = off_len_q - CNT_W'(1);
   assign on_end        = sym_en && (cnt_q == on_last);
   assign off_end       = sym_en && (cnt_q == off_last);
   assign last_burst    = (bursts_q != '0) && (burst_cnt_q == bursts_q - BURST_W'(1));
   assign burst_cnt_inc = (&burst_cnt_q) ? burst_cnt_q : burst_cnt_q + BURST_W'(1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      on_len_d    = on_len_q;
      off_len_d   = off_len_q;
      bursts_d    = bursts_q;
      burst_cnt_d = burst_cnt_q;
      stop_pend_d = stop_pend_q;
      bs_d        = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            stop_pend_d = 1'b0;
            if (start && !stop) begin
               on_len_d    = cfg_on_len;
               off_len_d   = cfg_off_len;
               bursts_d    = cfg_bursts;
               cnt_d       = '0;
               burst_cnt_d = '0;
               state_d     = S_ON;
               bs_d        = 1'b1;
            end
         end

         S_ON: begin
            if (stop) begin
               stop_pend_d = 1'b1;
            end
            if (on_end) begin
               burst_cnt_d = burst_cnt_inc;
               cnt_d       = '0;
               // A stop arriving on the final strobe still ends the sequence here.
               if (stop_pend_q || stop || last_burst) begin
                  state_d     = S_IDLE;
                  done_d      = 1'b1;
                  stop_pend_d = 1'b0;
               end else if (off_len_q == '0) begin
                  bs_d = 1'b1;
               end else begin
                  state_d = S_OFF;
               end
            end else if (sym_en) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_OFF: begin
            if (stop) begin
               state_d     = S_IDLE;
               done_d      = 1'b1;
               cnt_d       = '0;
               stop_pend_d = 1'b0;
            end else if (off_end) begin
               state_d = S_ON;
               bs_d    = 1'b1;
               cnt_d   = '0;
            end else if (sym_en) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            stop_pend_d = 1'b0;
         end
      endcase

      mode_d = (state_d != S_ON);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         on_len_q    <= '0;
         off_len_q   <= '0;
         bursts_q    <= '0;
         burst_cnt_q <= '0;
         stop_pend_q <= 1'b0;
         mode_q      <= 1'b1;
         busy_q      <= 1'b0;
         bs_q        <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         on_len_q    <= on_len_d;
         off_len_q   <= off_len_d;
         bursts_q    <= bursts_d;
         burst_cnt_q <= burst_cnt_d;
         stop_pend_q <= stop_pend_d;
         mode_q      <= mode_d;
         busy_q      <= busy_d;
         bs_q        <= bs_d;
         done_q      <= done_d;
      end
   end

   assign mode        = mode_q;
   assign busy        = busy_q;
   assign burst_start = bs_q;
   assign done        = done_q;

endmodule

// File: tb/tb_on_off_scheduler.sv
// Directed bench for on_off_scheduler: per-cycle vector table plus a hand-written async reset sequence.
// Expected outputs are packed as {mode, busy, burst_start, done}, observed during the vector's cycle.

module tb_on_off_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sym_en = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] cfg_on_len = '0;
   logic [15:0] cfg_off_len = '0;
   logic [7:0]  cfg_bursts = '0;
   logic        mode, busy, burst_start, done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        st;
      logic        sp;
      logic        se;
      logic [15:0] on_len;
      logic [15:0] off_len;
      logic [7:0]  bursts;
      logic [3:0]  exp;
   } vec_t;

   vec_t vq[$];

   on_off_scheduler #(.CNT_W(16), .BURST_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sym_en      (sym_en),
      .start       (start),
      .stop        (stop),
      .cfg_on_len  (cfg_on_len),
      .cfg_off_len (cfg_off_len),
      .cfg_bursts  (cfg_bursts),
      .mode        (mode),
      .busy        (busy),
      .burst_start (burst_start),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic add(input logic st, input logic sp, input logic se,
                      input int on_len, input int off_len, input int bursts,
                      input logic [3:0] exp);
      vec_t v;
      v.st      = st;
      v.sp      = sp;
      v.se      = se;
      v.on_len  = 16'(on_len);
      v.off_len = 16'(off_len);
      v.bursts  = 8'(bursts);
      v.exp     = exp;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [3:0] exp);
      logic [3:0] act;
      act = {mode, busy, burst_start, done};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got mode/busy/bs/done=%b expected %b", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: fixed bursts, on=3 off=2 bursts=2
      add(1,0,1, 3,2,2, 4'b1000);
      add(0,0,1, 3,2,2, 4'b0110);
      add(0,0,1, 3,2,2, 4'b0100);
      add(0,0,1, 3,2,2, 4'b0100);
      add(0,0,1, 3,2,2, 4'b1100);
      add(0,0,1, 3,2,2, 4'b1100);
      add(0,0,1, 3,2,2, 4'b0110);
      add(0,0,1, 3,2,2, 4'b0100);
      add(0,0,1, 3,2,2, 4'b0100);
      add(0,0,1, 3,2,2, 4'b1001);
      add(0,0,1, 3,2,2, 4'b1000);
      // 2: continuous, stop inside ON completes the period
      add(1,0,1, 4,1,0, 4'b1000);
      add(0,0,1, 4,1,0, 4'b0110);
      add(0,1,1, 4,1,0, 4'b0100);
      add(0,0,1, 4,1,0, 4'b0100);
      add(0,0,1, 4,1,0, 4'b0100);
      add(0,0,1, 4,1,0, 4'b1001);
      add(0,0,1, 4,1,0, 4'b1000);
      // 3a: stop inside OFF
      add(1,0,1, 2,3,0, 4'b1000);
      add(0,0,1, 2,3,0, 4'b0110);
      add(0,0,1, 2,3,0, 4'b0100);
      add(0,0,1, 2,3,0, 4'b1100);
      add(0,1,1, 2,3,0, 4'b1100);
      add(0,0,1, 2,3,0, 4'b1001);
      add(0,0,1, 2,3,0, 4'b1000);
      // 3b: zero-length ON and OFF, three back-to-back bursts
      add(1,0,1, 0,0,3, 4'b1000);
      add(0,0,1, 0,0,3, 4'b0110);
      add(0,0,1, 0,0,3, 4'b0110);
      add(0,0,1, 0,0,3, 4'b0110);
      add(0,0,1, 0,0,3, 4'b1001);
      add(0,0,1, 0,0,3, 4'b1000);
      // 4: strobe every 4th cycle, counter frozen in between
      add(1,0,0, 2,1,1, 4'b1000);
      add(0,0,0, 2,1,1, 4'b0110);
      add(0,0,0, 2,1,1, 4'b0100);
      add(0,0,1, 2,1,1, 4'b0100);
      add(0,0,0, 2,1,1, 4'b0100);
      add(0,0,0, 2,1,1, 4'b0100);
      add(0,0,0, 2,1,1, 4'b0100);
      add(0,0,1, 2,1,1, 4'b0100);
      add(0,0,0, 2,1,1, 4'b1001);
      add(0,0,0, 2,1,1, 4'b1000);
      // 5b: start and stop together in IDLE
      add(1,1,1, 2,1,1, 4'b1000);
      add(0,0,1, 2,1,1, 4'b1000);
      add(0,0,1, 2,1,1, 4'b1000);
      // 5c: start held while busy is ignored
      add(1,0,1, 2,1,1, 4'b1000);
      add(1,0,1, 2,1,1, 4'b0110);
      add(1,0,1, 2,1,1, 4'b0100);
      add(0,0,1, 2,1,1, 4'b1001);
      add(0,0,1, 2,1,1, 4'b1000);
      // 5d: cfg changes while busy have no effect
      add(1,0,1, 3,0,1, 4'b1000);
      add(0,0,1, 1,0,0, 4'b0110);
      add(0,0,1, 1,5,0, 4'b0100);
      add(0,0,1, 1,5,0, 4'b0100);
      add(0,0,1, 1,5,0, 4'b1001);
      add(0,0,1, 1,5,0, 4'b1000);
      // stop in IDLE leaves no pending stop: two bursts still run
      add(0,1,1, 1,0,2, 4'b1000);
      add(1,0,1, 1,0,2, 4'b1000);
      add(0,0,1, 1,0,2, 4'b0110);
      add(0,0,1, 1,0,2, 4'b0110);
      add(0,0,1, 1,0,2, 4'b1001);
      add(0,0,1, 1,0,2, 4'b1000);

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_held", 4'b1000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_idle", 4'b1000);

      for (int i = 0; i < vq.size(); i++) begin
         check($sformatf("vec%0d", i), vq[i].exp);
         start       = vq[i].st;
         stop        = vq[i].sp;
         sym_en      = vq[i].se;
         cfg_on_len  = vq[i].on_len;
         cfg_off_len = vq[i].off_len;
         cfg_bursts  = vq[i].bursts;
         @(posedge clk);
         #1;
      end

      // 5a: reset asserted mid-ON acts without a clock edge, no done afterwards
      start       = 1'b1;
      stop        = 1'b0;
      sym_en      = 1'b1;
      cfg_on_len  = 16'd5;
      cfg_off_len = 16'd0;
      cfg_bursts  = 8'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("rst_seq_on", 4'b0110);
      @(posedge clk);
      #1;
      check("rst_seq_on2", 4'b0100);
      rst_n = 1'b0;
      #1;
      check("rst_async", 4'b1000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("rst_after%0d", k), 4'b1000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
